// File: rtl/fb_pkg.sv
`default_nettype none
//==============================================================================
// Module   : fb_pkg
// Brief    : shared state encoding, buffer-index width helper and default sizes
// Revision : 1.0 - initial release
//==============================================================================
package fb_pkg;

    typedef enum logic [1:0] {
        FB_RENDER    = 2'd0,
        FB_WAIT_SWAP = 2'd1,
        FB_CLEAR     = 2'd2
    } fb_state_e;

    localparam int DEF_ADDR_W   = 19;
    localparam int DEF_PIX_W    = 4;
    localparam int DEF_FB_WORDS = 307200;

    // A single buffer would otherwise give a zero-width index.
    function automatic int buf_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fb_clear_engine.sv
`default_nettype none
//==============================================================================
// Module   : fb_clear_engine
// Brief    : sweeps addresses 0..FB_WORDS-1 one per cycle while en is high
// Revision : 1.0 - initial release
//==============================================================================
module fb_clear_engine
    import fb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int FB_WORDS = DEF_FB_WORDS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic [ADDR_W-1:0] addr,
    output logic              we,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WORDS - 1);

    logic [ADDR_W-1:0] r_addr;
    logic              w_last;

    assign w_last = en && (r_addr == LAST_ADDR);

    // Counter rests at zero whenever the sweep is idle so every entry starts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
        end else if (!en || w_last) begin
            r_addr <= '0;
        end else begin
            r_addr <= r_addr + 1'b1;
        end
    end

    assign addr = r_addr;
    assign we   = en;
    assign done = w_last;

endmodule
`default_nettype wire

// File: rtl/framebuffer_swap_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : framebuffer_swap_ctrl
// Brief    : double/triple framebuffer swap controller, vsync-locked per channel;
//            hardware back-buffer clear is built only when FB_HW_CLEAR_EN is defined
// Revision : 1.0 - initial release
//==============================================================================
module framebuffer_swap_ctrl
    import fb_pkg::*;
#(
    parameter  int NUM_BUFS = 2,
    parameter  int NUM_RD   = 2,
    parameter  int ADDR_W   = DEF_ADDR_W,
    parameter  int PIX_W    = DEF_PIX_W,
    parameter  int FB_WORDS = DEF_FB_WORDS,
    localparam int BUF_W    = buf_w(NUM_BUFS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_RD-1:0]       vsync,
    input  logic                    render_done,
    output logic                    render_ready,
    output logic [BUF_W-1:0]        back_sel,
    output logic [NUM_RD*BUF_W-1:0] rd_sel,
    output logic [ADDR_W-1:0]       clr_addr,
    output logic [PIX_W-1:0]        clr_data,
    output logic                    clr_we,
    output logic [15:0]             frame_cnt,
    output logic [15:0]             drop_cnt
);

    localparam logic [1:0] RENDER    = FB_RENDER;
    localparam logic [1:0] WAIT_SWAP = FB_WAIT_SWAP;
    localparam logic [1:0] CLEAR     = FB_CLEAR;

    localparam bit               TRIPLE    = (NUM_BUFS >= 3);
    localparam logic [BUF_W-1:0] RST_FRONT = '0;
    localparam logic [BUF_W-1:0] RST_BACK  = BUF_W'(1);
    localparam logic [BUF_W-1:0] RST_PEND  = TRIPLE ? BUF_W'(2) : '0;

    logic [1:0]        r_state;
    logic [BUF_W-1:0]  r_front;
    logic [BUF_W-1:0]  r_back;
    logic [BUF_W-1:0]  r_pend;
    logic              r_pvld;
    logic [NUM_RD-1:0] r_vs_d;
    logic [NUM_RD-1:0] r_edge;
    logic [BUF_W-1:0]  r_rd [NUM_RD];
    logic [15:0]       r_frame;
    logic [15:0]       r_drop;

    logic [1:0]        w_state;
    logic [BUF_W-1:0]  w_front;
    logic [BUF_W-1:0]  w_back;
    logic [BUF_W-1:0]  w_pend;
    logic [BUF_W-1:0]  w_tmp;
    logic              w_pvld;
    logic [15:0]       w_frame;
    logic [15:0]       w_drop;
    logic              w_clr_done;
    logic              w_rd_hit;

`ifdef FB_HW_CLEAR_EN
    localparam logic [1:0] AFTER_FILL = CLEAR;

    logic w_clr_en;
    assign w_clr_en = (r_state == CLEAR);

    fb_clear_engine #(
        .ADDR_W   (ADDR_W),
        .FB_WORDS (FB_WORDS)
    ) u_clear (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_clr_en),
        .addr  (clr_addr),
        .we    (clr_we),
        .done  (w_clr_done)
    );
    assign clr_data = '0;
`else
    localparam logic [1:0] AFTER_FILL = RENDER;

    assign clr_addr   = '0;
    assign clr_data   = '0;
    assign clr_we     = 1'b0;
    assign w_clr_done = 1'b0;
`endif

    // The ch0 swap is resolved first; render_done then sees the post-swap roles.
    always_comb begin
        w_state = r_state;
        w_front = r_front;
        w_back  = r_back;
        w_pend  = r_pend;
        w_pvld  = r_pvld;
        w_frame = r_frame;
        w_drop  = r_drop;
        w_tmp   = r_back;

        if (r_edge[0]) begin
            if (!TRIPLE && (r_state == WAIT_SWAP)) begin
                w_front = r_back;
                w_back  = r_front;
                w_frame = r_frame + 16'd1;
                w_state = AFTER_FILL;
            end else if (TRIPLE && r_pvld) begin
                w_front = r_pend;
                w_pend  = r_front;
                w_pvld  = 1'b0;
                w_frame = r_frame + 16'd1;
            end
        end

        if (render_done) begin
            if (w_state == RENDER) begin
                if (TRIPLE) begin
                    // Finished back becomes pending; the displaced pending (or free) buffer is reused.
                    w_tmp   = w_back;
                    w_back  = w_pend;
                    w_pend  = w_tmp;
                    w_pvld  = 1'b1;
                    w_state = AFTER_FILL;
                end else begin
                    w_state = WAIT_SWAP;
                end
            end else if (r_drop != 16'hFFFF) begin
                w_drop = r_drop + 16'd1;
            end
        end

        if ((r_state == CLEAR) && w_clr_done) begin
            w_state = RENDER;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RENDER;
            r_front <= RST_FRONT;
            r_back  <= RST_BACK;
            r_pend  <= RST_PEND;
            r_pvld  <= 1'b0;
            r_vs_d  <= '0;
            r_edge  <= '0;
            r_frame <= '0;
            r_drop  <= '0;
        end else begin
            r_state <= w_state;
            r_front <= w_front;
            r_back  <= w_back;
            r_pend  <= w_pend;
            r_pvld  <= w_pvld;
            r_vs_d  <= vsync;
            r_edge  <= vsync & ~r_vs_d;
            r_frame <= w_frame;
            r_drop  <= w_drop;
        end
    end

    generate
        for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rd[i] <= '0;
                end else if (r_edge[i]) begin
                    r_rd[i] <= w_front;
                end
            end
            assign rd_sel[i*BUF_W +: BUF_W] = r_rd[i];
        end
    endgenerate

    always_comb begin
        w_rd_hit = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (r_rd[i] == r_back) begin
                w_rd_hit = 1'b1;
            end
        end
    end

    assign render_ready = (r_state == RENDER) && !w_rd_hit;
    assign back_sel     = r_back;
    assign frame_cnt    = r_frame;
    assign drop_cnt     = r_drop;

endmodule
`default_nettype wire

// File: doc/framebuffer_swap_ctrl.md
FRAMEBUFFER_SWAP_CTRL -- requirements
Module: framebuffer_swap_ctrl

Interface
REQ-001 Parameter NUM_BUFS, default 2, buffer count (2 = double, 3 = triple buffering).
REQ-002 Parameter NUM_RD, default 2, number of screen read channels (1..4; ch0 = VGA, ch1 = LCD).
REQ-003 Parameter ADDR_W, default 19, framebuffer address width.
REQ-004 Parameter PIX_W, default 4, palette-index width.
REQ-005 Parameter FB_WORDS, default 307200, pixels per buffer.
REQ-006 clk  input  1  pixel clock; the block has one clock; reset is asynchronous and active-low.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 vsync  input  NUM_RD  per-channel vsync; ch0 is the global swap reference.
REQ-009 render_done  input  1  one-cycle pulse: renderer finished the back buffer.
REQ-010 render_ready  output  1  renderer may write the back buffer.
REQ-011 back_sel  output  BUF_W  buffer index the renderer writes.
REQ-012 rd_sel  output  NUM_RD*BUF_W  per-channel latched front index.
REQ-013 clr_addr  output  ADDR_W  clear-engine write address.
REQ-014 clr_data  output  PIX_W  clear colour (0).
REQ-015 clr_we  output  1  clear-engine write enable.
REQ-016 frame_cnt  output  16  completed swaps, wraps 0xFFFF->0.
REQ-017 drop_cnt  output  16  render_done pulses ignored, saturates at 0xFFFF.

Function
REQ-018 vsync edges SHALL be detected as a rising edge per channel, registered; an edge acts on the cycle after it is seen.
REQ-019 FSM states SHALL be RENDER, WAIT_SWAP, CLEAR; only RENDER asserts render_ready, and only when back_sel differs from every rd_sel.
REQ-020 Double mode: render_done in RENDER -> WAIT_SWAP; on the next ch0 edge front<=back, back<=old front, frame_cnt+1, -> CLEAR (or RENDER if clear is compiled out).
REQ-021 Triple mode: render_done in RENDER moves back into pending (pending_vld=1), back<=the free buffer, and the FSM stays in RENDER (or goes to CLEAR); a ch0 edge with pending_vld sets front<=pending, clears pending_vld, frame_cnt+1.
REQ-022 Triple mode: render_done while pending_vld=1 SHALL replace pending with the new buffer and free the old pending buffer (newest frame wins).
REQ-023 Each rd_sel[i] SHALL load the current front only on the rising edge of vsync[i], so no channel changes buffer mid-frame.
REQ-024 render_done outside RENDER SHALL be ignored and SHALL increment drop_cnt.
REQ-025 When a ch0 edge and render_done occur in the same cycle, the swap SHALL use the pre-pulse state; the pulse is then evaluated against the post-swap state in the same cycle.
REQ-026 BUF_W SHALL be $clog2(NUM_BUFS); index values >= NUM_BUFS SHALL never appear on any output.

Reset
REQ-027 While rst_n=0: front=0, back=1, pending=2 with pending_vld=0, all rd_sel=0, state=RENDER, render_ready=1, clr_*=0, both counters=0.
REQ-028 Deasserting rst_n during CLEAR SHALL abort the sweep with no further clr_we.

Configuration
REQ-029 Macro FB_HW_CLEAR_EN defined: on entry to CLEAR, write clr_data to addresses 0..FB_WORDS-1 of back_sel at one per cycle (clr_we=1); return to RENDER the cycle after the last write (FB_WORDS cycles of clr_we).
REQ-030 FB_HW_CLEAR_EN undefined: the CLEAR state is absent, clr_we/clr_addr/clr_data are tied to 0, and render_ready SHALL rise the cycle after the swap.

Structure
REQ-031 Package fb_pkg SHALL hold the state enum, the BUF_W function and default ADDR_W/PIX_W/FB_WORDS constants.
REQ-032 Sub-module fb_clear_engine (address counter, done flag) SHALL be instantiated only under FB_HW_CLEAR_EN.

Verification
REQ-033 Double, NUM_RD=2: reset, render_done at t=10, ch0 edge at t=50 -> back_sel=0, front=1, frame_cnt=1, render_ready=0 until the clear completes.
REQ-034 rd_sel latch: ch1 edge 20 cycles after ch0 -> rd_sel[1] changes exactly at that edge, and render_ready stays 0 while back_sel equals rd_sel[1].
REQ-035 Triple: three render_done pulses before any ch0 edge -> drop_cnt=0, pending is the latest buffer, one ch0 edge gives frame_cnt=1.
REQ-036 Double: two render_done pulses before a ch0 edge -> drop_cnt=1.
REQ-037 Coincident render_done and ch0 edge -> behaviour as REQ-025 with no buffer index duplicated.
REQ-038 FB_WORDS=16 with clear enabled: clr_we high for 16 cycles over addresses 0..15; rst_n pulsed at address 7 -> clr_we=0 immediately.
